// File: rtl/analog_wcfg_engine.sv
// Weight-configuration engine: streams a window of J-rows from wmem into the
// analog Ising array, one row per write pulse, with wrap-around row indexing.
module analog_wcfg_engine #(
  parameter int unsigned NUM_SPIN   = 256,
  parameter int unsigned BIT_J      = 4,
  parameter int unsigned NUM_ROWS   = 256,
  parameter int unsigned MEM_RD_LAT = 1,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              start_i,
  input  logic                              abort_i,
  input  logic [$clog2(NUM_ROWS)-1:0]       row_base_i,
  input  logic [$clog2(NUM_ROWS):0]         row_cnt_i,
  input  logic [CNT_W-1:0]                  hi_cycles_i,
  input  logic [CNT_W-1:0]                  lo_cycles_i,
  output logic                              mem_ren_o,
  output logic [$clog2(NUM_ROWS)-1:0]       mem_raddr_o,
  input  logic [NUM_SPIN*BIT_J-1:0]         mem_rdata_i,
  output logic                              analog_wen_o,
  output logic [NUM_ROWS-1:0]               analog_waddr_o,
  output logic [NUM_SPIN*BIT_J-1:0]         analog_wdata_o,
  output logic                              busy_o,
  output logic                              done_o,
  output logic                              aborted_o,
  output logic [$clog2(NUM_ROWS):0]         rows_done_o
);

  localparam int unsigned AW = $clog2(NUM_ROWS);
  localparam int unsigned RW = AW + 1;
  localparam int unsigned DW = NUM_SPIN * BIT_J;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_HIGH,
    S_LOW,
    S_DONE
  } state_t;

  state_t            state_q, state_n;
  logic [AW-1:0]     cur_row_q, cur_row_n, row_next;
  logic [RW-1:0]     cnt_q, cnt_n, cnt_sat, rows_n, rows_inc;
  logic [CNT_W-1:0]  hi_q, hi_n, lo_q, lo_n, tmr_q, tmr_n, hi_eff;
  logic              tmr_last;

  logic              ren_n, wen_n, busy_n, done_n, aborted_n;
  logic [AW-1:0]     raddr_n;
  logic [NUM_ROWS-1:0] waddr_n;
  logic [DW-1:0]     wdata_n;

  // Small helpers: row-count saturation, wrapping row increment, pulse length.
  assign cnt_sat  = (row_cnt_i > RW'(NUM_ROWS)) ? RW'(NUM_ROWS) : row_cnt_i;
  assign row_next = (cur_row_q == AW'(NUM_ROWS - 1)) ? '0 : cur_row_q + AW'(1);
  assign rows_inc = rows_done_o + RW'(1);
  assign hi_eff   = (hi_q == '0) ? CNT_W'(1) : hi_q;
  assign tmr_last = (tmr_q == CNT_W'(1));

  // Next-state and next-output decode; outputs follow the next state so they
  // line up with the state register one edge later.
  always_comb begin
    state_n   = state_q;
    cur_row_n = cur_row_q;
    cnt_n     = cnt_q;
    hi_n      = hi_q;
    lo_n      = lo_q;
    tmr_n     = tmr_q;
    rows_n    = rows_done_o;
    ren_n     = 1'b0;
    raddr_n   = '0;
    wen_n     = 1'b0;
    waddr_n   = '0;
    wdata_n   = '0;
    busy_n    = 1'b0;
    done_n    = 1'b0;
    aborted_n = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start_i && !abort_i) begin
          cur_row_n = row_base_i;
          cnt_n     = cnt_sat;
          hi_n      = hi_cycles_i;
          lo_n      = lo_cycles_i;
          rows_n    = '0;
          state_n   = (cnt_sat == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        tmr_n   = CNT_W'(MEM_RD_LAT);
        state_n = S_WAIT;
      end
      S_WAIT: begin
        if (tmr_last) begin
          tmr_n   = hi_eff;
          state_n = S_HIGH;
        end else begin
          tmr_n = tmr_q - CNT_W'(1);
        end
      end
      S_HIGH: begin
        if (tmr_last) begin
          rows_n    = rows_inc;
          cur_row_n = row_next;
          if (lo_q != '0) begin
            tmr_n   = lo_q;
            state_n = S_LOW;
          end else begin
            state_n = (rows_inc == cnt_q) ? S_DONE : S_FETCH;
          end
        end else begin
          tmr_n = tmr_q - CNT_W'(1);
        end
      end
      S_LOW: begin
        if (tmr_last) begin
          state_n = (rows_done_o == cnt_q) ? S_DONE : S_FETCH;
        end else begin
          tmr_n = tmr_q - CNT_W'(1);
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase

    // Abort overrides any progress; the row count is frozen where it stood.
    if (state_q != S_IDLE && abort_i) begin
      state_n   = S_IDLE;
      rows_n    = rows_done_o;
      aborted_n = 1'b1;
    end

    busy_n = (state_n != S_IDLE);
    done_n = (state_n == S_DONE) && !aborted_n;
    if (state_n == S_FETCH) begin
      ren_n   = 1'b1;
      raddr_n = cur_row_n;
    end
    if (state_n == S_HIGH) begin
      wen_n   = 1'b1;
      waddr_n = NUM_ROWS'(1) << cur_row_n;
      wdata_n = (state_q == S_WAIT) ? mem_rdata_i : analog_wdata_o;
    end
  end

  // State, job parameters and registered outputs.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q        <= S_IDLE;
      cur_row_q      <= '0;
      cnt_q          <= '0;
      hi_q           <= '0;
      lo_q           <= '0;
      tmr_q          <= '0;
      rows_done_o    <= '0;
      mem_ren_o      <= 1'b0;
      mem_raddr_o    <= '0;
      analog_wen_o   <= 1'b0;
      analog_waddr_o <= '0;
      analog_wdata_o <= '0;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
      aborted_o      <= 1'b0;
    end else begin
      state_q        <= state_n;
      cur_row_q      <= cur_row_n;
      cnt_q          <= cnt_n;
      hi_q           <= hi_n;
      lo_q           <= lo_n;
      tmr_q          <= tmr_n;
      rows_done_o    <= rows_n;
      mem_ren_o      <= ren_n;
      mem_raddr_o    <= raddr_n;
      analog_wen_o   <= wen_n;
      analog_waddr_o <= waddr_n;
      analog_wdata_o <= wdata_n;
      busy_o         <= busy_n;
      done_o         <= done_n;
      aborted_o      <= aborted_n;
    end
  end

endmodule
